// File: rtl/bcd_scan_display_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display_if
// Description : Bundle between a BCD number source and the 4-digit scanned
//               7-segment driver. The master side supplies the load strobe
//               and digits; the slave side (the driver) returns segment and
//               anode drive plus the end-of-frame pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_scan_display_if;
    logic       ld;
    logic [3:0] n1;
    logic [3:0] n2;
    logic [3:0] n3;
    logic [3:0] n4;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    modport master (
        output ld, n1, n2, n3, n4,
        input  seg, an, frame_done
    );

    modport slave (
        input  ld, n1, n2, n3, n4,
        output seg, an, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display
// Description : Latches a four-digit BCD word on a load strobe and scans it
//               onto a common-anode 7-segment display (active-low segments
//               {g,f,e,d,c,b,a}, active-low anodes). Each digit is driven for
//               SCAN_DIV cycles; frame_done pulses when slot 0 comes round
//               again after a complete four-slot scan.
//               Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above
//               the most significant nonzero digit (slot 0 never blanked).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  wire logic            clk,
    input  wire logic            enb,
    bcd_scan_display_if.slave    bus
);

    // Last prescaler value of a slot; prescaler is 16 bits wide.
    localparam logic [15:0] c_DIV_LAST = 16'(SCAN_DIV - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  dig_q [4];
    logic [3:0]  dig_d [4];
    logic [1:0]  slot_q, slot_d;
    logic [15:0] presc_q, presc_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  blank_mask;

    // Active-low gfedcba pattern; non-BCD codes show a dash (g only).
    function automatic logic [6:0] seg_enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // State register, digit latches, scan counters and registered outputs.
    always_ff @(posedge clk or posedge enb) begin
        if (enb) begin
            state_q      <= IDLE;
            for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
            slot_q       <= 2'd0;
            presc_q      <= 16'd0;
            seg_q        <= 7'h7F;
            an_q         <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
            slot_q       <= slot_d;
            presc_q      <= presc_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next state: load takes priority over a prescaler wrap; outputs are
    // decoded from the next slot/digits so they change with the slot itself.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        presc_d      = presc_q;
        for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];
        frame_done_d = 1'b0;
        seg_d        = 7'h7F;
        an_d         = 4'hF;
        blank_mask   = 4'b0000;

        if (bus.ld) begin
            dig_d[0] = bus.n1;
            dig_d[1] = bus.n2;
            dig_d[2] = bus.n3;
            dig_d[3] = bus.n4;
            slot_d   = 2'd0;
            presc_d  = 16'd0;
            state_d  = SHOW;
        end else if (state_q == SHOW) begin
            if (presc_q == c_DIV_LAST) begin
                presc_d      = 16'd0;
                slot_d       = slot_q + 2'd1;
                frame_done_d = (slot_q == 2'd3);
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end

`ifdef LEADING_ZERO_BLANK_EN
        // A slot is blanked when it and every higher digit are zero.
        blank_mask[3] = (dig_d[3] == 4'd0);
        blank_mask[2] = blank_mask[3] && (dig_d[2] == 4'd0);
        blank_mask[1] = blank_mask[2] && (dig_d[1] == 4'd0);
        blank_mask[0] = 1'b0;
`else
        blank_mask = 4'b0000;
`endif

        if ((state_d == SHOW) && !blank_mask[slot_d]) begin
            an_d  = ~(4'b0001 << slot_d);
            seg_d = seg_enc(dig_d[slot_d]);
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Reader for the four-digit BCD word (n1 ones … n4 thousands) produced by the team's digit-generating blocks.
- On a load strobe it latches the four digits, then time-multiplexes them onto one common-anode 7-segment bus with per-digit anode enables.
- Pulses frame_done after every complete scan of all four digits.
- Sits between the number source and the board's 4-digit LED display.

Parameters:
SCAN_DIV, 1000, clk cycles each digit is driven per scan slot; legal 1..65535 (16-bit prescaler)

Ports:
clk  input  1  system clock; all logic on rising edge
enb  input  1  asynchronous active-high reset
ld  input  1  load strobe; sampled on rising clk; latches n1..n4
n1  input  4  BCD ones digit (slot 0, an[0], rightmost)
n2  input  4  BCD tens digit (slot 1, an[1])
n3  input  4  BCD hundreds digit (slot 2, an[2])
n4  input  4  BCD thousands digit (slot 3, an[3], leftmost)
seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
an  output  4  digit anode enables, active-low, one-hot-low when showing
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (enb=1, async, no clock needed):
  - seg=7'h7F, an=4'hF, frame_done=0.
  - Digit latches =0, slot index=0, prescaler=0, state=IDLE.
- States:
  - IDLE: display blank (an=F, seg=7F), prescaler held at 0. Leaves IDLE only on ld=1 → SHOW.
  - SHOW: continuous scan. No return to IDLE except via enb.
- Load:
  - ld=1 at edge t latches n1..n4 and clears slot index and prescaler, in any state.
  - Outputs are registered. At t+1, an=4'b1110 and seg shows the new n1.
  - ld held high re-latches every cycle; slot stays 0 and the scan does not advance.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the slot advances 0→1→2→3→0.
  - Each slot is visible for exactly SCAN_DIV cycles. A full frame is 4*SCAN_DIV cycles.
  - an = ~(4'b0001 << slot). seg = encoding of the latched digit for the slot.
  - Output registers update in the same cycle as the slot change; no dead/blanking cycle between slots.
- frame_done:
  - Registered; high for exactly one cycle, the same cycle an returns to 4'b1110 after slot 3 completes.
  - A frame cut short by ld or enb produces no pulse.
- Segment encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10..15 = 0111111 (dash, only g lit).
- Simultaneous events:
  - enb overrides everything.
  - ld wins over a prescaler wrap in the same cycle; slot forced to 0, no frame_done.
- Input digits are not observed except on ld edges; changes between loads have no effect.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any latched digit of value 0 above the most significant nonzero digit is blanked during its slot (an bit held 1, seg=7'h7F).
  - Slot 0 is never blanked, so all-zero shows a single "0".
  - Invalid digits (>9) count as nonzero.
  - Slot timing and frame_done are unchanged.
- Undefined: all four digits are always shown, zeros included.

Test Plan (SCAN_DIV=4):
1. Pulse enb, run 20 cycles with ld=0 → an=F, seg=7F, frame_done=0 throughout; also assert enb between clock edges mid-scan → outputs blank immediately, state IDLE.
2. ld=1 for one cycle with n4..n1=1,2,3,4 → next cycle an=1110 seg=0011001; +4 an=1101 seg=0110000; +8 an=1011 seg=0100100; +12 an=0111 seg=1111001; +16 an=1110 with frame_done=1 for one cycle.
3. Load n4..n1=9,8,11,0 → slot 1 shows seg=0111111 (dash); slot 3 shows 0010000.
4. Load 1,2,3,4, then at cycle 10 of the frame (slot 2) load 5,6,7,8 → next cycle an=1110 seg=0000000 (8); no frame_done at the old frame boundary; first pulse 16 cycles after the reload.
5. ld held high 10 cycles → an stays 1110, no slot advance, no frame_done; release → normal scan resumes from slot 0.
6. LEADING_ZERO_BLANK_EN defined:
   - Load 0,0,0,7 → slots 1..3 an=F seg=7F, slot 0 shows 7.
   - Load 0,5,0,0 → slot 3 blank; slots 2..0 show 5,0,0.
   - Load 0,0,0,0 → only slot 0 shows 1000000.
